tile_blitter: RTL
=================

Name: tile_blitter

Overview:
- Parametrised successor to the fixed 8x8 block printer.
- Draws one TILE_W x TILE_H tile at a latched (x, y) origin into the VGA adapter pixel-write port, one pixel per clock.
- Supports solid fill, glyph (opaque or transparent) and clear modes, with clipping at the screen edge.
- Sits between game/test control logic and the vga_adapter, using a start/busy/done handshake.

Parameters:
- TILE_W, 8, tile width in pixels (1..32)
- TILE_H, 8, tile height in pixels (1..32)
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- COLOR_W, 3, colour width
- SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are clipped
- SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are clipped

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a draw; sampled only in IDLE
- mode  in  2  00 fill, 01 glyph opaque, 10 glyph transparent, 11 clear
- x_in  in  X_W  tile origin x (left)
- y_in  in  Y_W  tile origin y (top)
- fg_color  in  COLOR_W  foreground / fill colour
- bg_color  in  COLOR_W  background colour (mode 01 only)
- glyph  in  TILE_W*TILE_H  bitmap; bit r*TILE_W+c is row r, col c; bit 0 = top-left
- busy  out  1  high while drawing
- done  out  1  one-cycle pulse after the last pixel slot
- plot  out  1  pixel write strobe to vga_adapter
- x_out  out  X_W  pixel x
- y_out  out  Y_W  pixel y
- color_out  out  COLOR_W  pixel colour

Behaviour:
- Reset is asynchronous, active-high: state=IDLE; busy, done, plot = 0; x_out, y_out, color_out = 0; counters = 0.
- All outputs are registered.
- States:
  - IDLE: start=1 latches x_in, y_in, mode, fg_color, bg_color, glyph; col=row=0; go to DRAW; busy=1 from the next cycle.
  - DRAW: one pixel slot per cycle, row-major (col increments fastest). At col=TILE_W-1, col wraps to 0 and row increments. After slot (TILE_W-1, TILE_H-1), go to DONE.
  - DONE: done=1, busy=0, plot=0 for exactly one cycle; return to IDLE.
- Per slot: x_out = x0+col and y_out = y0+row, computed at X_W+1 / Y_W+1 bits for the clip test and truncated on output.
- Colour and plot per mode:
  - 00: color_out = fg_color, plot=1.
  - 11: color_out = 0, plot=1.
  - 01: color_out = glyph bit ? fg_color : bg_color, plot=1.
  - 10: if glyph bit=1, color_out = fg_color and plot=1; otherwise plot=0.
- Clipping: if x0+col >= SCREEN_W or y0+row >= SCREEN_H, plot=0. The slot is still consumed.
- Fixed latency: start accepted at edge 0; pixel slots appear on edges 1..TILE_W*TILE_H; done is high after edge TILE_W*TILE_H+1; next start is accepted in the cycle after done.
- start while busy or in DONE is ignored, with no queuing. Input changes during DRAW have no effect because all inputs are latched.
- start held high continuously: a new draw begins each time IDLE is re-entered.
- plot is 0 in IDLE and DONE. x_out, y_out and color_out hold their last values when plot=0.
- reset during DRAW: plot and busy drop immediately (asynchronously) with no done pulse; the partial tile remains on screen.

Test Plan:
- Fill: mode=00, x=10, y=20, fg=3'b100 -> 64 plots, x 10..17 per row, y 20..27, colour 4, done pulse at edge 65, busy high for edges 1..64.
- Opaque glyph: mode=01, glyph=64'hAA55AA55AA55AA55, fg=7, bg=1 -> 64 plots. Pixel (0,0) bit 0=1 gives colour 7; pixel (1,0) gives colour 1.
- Transparent glyph: mode=10, same glyph -> exactly 32 plots, all colour fg. done still at edge 65.
- Clipping: mode=00, x=156, y=116, SCREEN 160x120 -> only x 156..159 and y 116..119 plot (16 plots). done at edge 65.
- Start while busy: second start at edge 30 with x=0 -> ignored, all 64 pixels use the first origin, exactly one done pulse.
- Reset mid-op: assert reset at slot 20 -> plot=0 and busy=0 without waiting for an edge, no done pulse. A new start after release draws a full tile.

Source files
------------

// File: rtl/tile_blitter.sv
// Tile blitter: draws one TILE_W x TILE_H tile at a latched origin into the
// VGA adapter pixel port, one pixel slot per clock, with screen-edge clipping.
module tile_blitter #(
  parameter int TILE_W   = 8,
  parameter int TILE_H   = 8,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOR_W  = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [X_W-1:0]            x_in,
  input  logic [Y_W-1:0]            y_in,
  input  logic [COLOR_W-1:0]        fg_color,
  input  logic [COLOR_W-1:0]        bg_color,
  input  logic [TILE_W*TILE_H-1:0]  glyph,
  output logic                      busy,
  output logic                      done,
  output logic                      plot,
  output logic [X_W-1:0]            x_out,
  output logic [Y_W-1:0]            y_out,
  output logic [COLOR_W-1:0]        color_out
);

  localparam int NPIX = TILE_W * TILE_H;
  localparam int CW   = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int RW   = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [X_W:0]  SCREEN_W_L = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]  SCREEN_H_L = (Y_W+1)'(SCREEN_H);
  localparam logic [CW-1:0] COL_LAST   = CW'(TILE_W - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(TILE_H - 1);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        col_reg, col_next;
  logic [RW-1:0]        row_reg, row_next;
  logic [X_W-1:0]       x0_reg, x0_next;
  logic [Y_W-1:0]       y0_reg, y0_next;
  logic [1:0]           mode_reg, mode_next;
  logic [COLOR_W-1:0]   fg_reg, fg_next;
  logic [COLOR_W-1:0]   bg_reg, bg_next;
  logic [NPIX-1:0]      glyph_reg, glyph_next;
  logic                 busy_next, done_next, plot_next;
  logic [X_W-1:0]       x_next;
  logic [Y_W-1:0]       y_next;
  logic [COLOR_W-1:0]   color_next;

  logic [X_W:0]         sum_x;
  logic [Y_W:0]         sum_y;
  logic [IW-1:0]        pix_idx;
  logic                 pix_bit, pix_on, visible;
  logic [COLOR_W-1:0]   pix_color;

  // One extra bit on the coordinate sums so origins near the wrap point clip
  // instead of wrapping back onto the left/top of the screen.
  assign sum_x   = {1'b0, x0_reg} + (X_W+1)'(col_reg);
  assign sum_y   = {1'b0, y0_reg} + (Y_W+1)'(row_reg);
  assign visible = (sum_x < SCREEN_W_L) && (sum_y < SCREEN_H_L);
  assign pix_idx = IW'(row_reg) * IW'(TILE_W) + IW'(col_reg);
  assign pix_bit = glyph_reg[pix_idx];

  always_comb begin
    pix_on    = 1'b1;
    pix_color = fg_reg;
    case (mode_reg)
      2'b00:   pix_color = fg_reg;
      2'b01:   pix_color = pix_bit ? fg_reg : bg_reg;
      2'b10:   pix_on    = pix_bit;
      default: pix_color = '0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    x0_next    = x0_reg;
    y0_next    = y0_reg;
    mode_next  = mode_reg;
    fg_next    = fg_reg;
    bg_next    = bg_reg;
    glyph_next = glyph_reg;
    busy_next  = busy;
    done_next  = 1'b0;
    plot_next  = 1'b0;
    x_next     = x_out;
    y_next     = y_out;
    color_next = color_out;
    case (state_reg)
      IDLE: begin
        if (start) begin
          x0_next    = x_in;
          y0_next    = y_in;
          mode_next  = mode;
          fg_next    = fg_color;
          bg_next    = bg_color;
          glyph_next = glyph;
          col_next   = '0;
          row_next   = '0;
          busy_next  = 1'b1;
          state_next = DRAW;
        end
      end
      DRAW: begin
        if (visible && pix_on) begin
          plot_next  = 1'b1;
          x_next     = sum_x[X_W-1:0];
          y_next     = sum_y[Y_W-1:0];
          color_next = pix_color;
        end
        if (col_reg == COL_LAST) begin
          col_next = '0;
          if (row_reg == ROW_LAST) state_next = DONE;
          else                     row_next   = row_reg + 1'b1;
        end else begin
          col_next = col_reg + 1'b1;
        end
      end
      DONE: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      col_reg   <= '0;
      row_reg   <= '0;
      x0_reg    <= '0;
      y0_reg    <= '0;
      mode_reg  <= '0;
      fg_reg    <= '0;
      bg_reg    <= '0;
      glyph_reg <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      plot      <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      color_out <= '0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
      x0_reg    <= x0_next;
      y0_reg    <= y0_next;
      mode_reg  <= mode_next;
      fg_reg    <= fg_next;
      bg_reg    <= bg_next;
      glyph_reg <= glyph_next;
      busy      <= busy_next;
      done      <= done_next;
      plot      <= plot_next;
      x_out     <= x_next;
      y_out     <= y_next;
      color_out <= color_next;
    end
  end

endmodule
